// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: CPU-facing register block for a UART core.
// It provides an 8-deep TX FIFO feeding a start/busy handshake sequencer,
// an 8-deep RX FIFO filled on rising edges of the core's rx_valid, and a
// level interrupt.
//
// state  | meaning
// T_IDLE | waiting for tx_en, a queued byte and an idle core
// T_REQ  | tx_start held with a stable byte until the core reports busy
// T_WAIT | byte accepted; waiting for the core to finish shifting
module uart_mmio_ctrl #(
    parameter  int FIFO_DEPTH = 8,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  bus_addr,
    input  logic        bus_wr,
    input  logic        bus_rd,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq,
    output logic [7:0]  uart_tx_byte,
    output logic        uart_tx_start,
    input  logic        uart_tx_busy,
    input  logic [7:0]  uart_rx_byte,
    input  logic        uart_rx_valid
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {T_IDLE, T_REQ, T_WAIT} tx_state_e;

    tx_state_e        state_q, state_d;
    logic [7:0]       tx_mem_q [FIFO_DEPTH];
    logic [7:0]       rx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CNT_W-1:0] tx_cnt_q, rx_cnt_q;
    logic [3:0]       ctrl_q;
    logic             rx_ovr_q, tx_ovf_q, rx_valid_q;
    logic [7:0]       tx_byte_q;
    logic             tx_start_q;
    logic [31:0]      rdata_q, rdata_d;

    logic tx_pop, tx_push, tx_ovf_set, tx_empty, tx_full, tx_idle;
    logic rx_pop, rx_push, rx_ovr_set, rx_empty, rx_full, rx_rise;
    logic rd_en, wr_data, wr_status, wr_ctrl;
    logic [31:0] status_w;

    // bus decode and FIFO handshake terms
    always_comb begin
        rd_en      = bus_rd && !bus_wr;
        wr_data    = bus_wr && (bus_addr == 2'd0);
        wr_status  = bus_wr && (bus_addr == 2'd1);
        wr_ctrl    = bus_wr && (bus_addr == 2'd2);
        tx_empty   = (tx_cnt_q == '0);
        tx_full    = (tx_cnt_q == FULL_CNT);
        rx_empty   = (rx_cnt_q == '0);
        rx_full    = (rx_cnt_q == FULL_CNT);
        tx_idle    = (state_q == T_IDLE) && !uart_tx_busy;
        // a full TX FIFO still accepts a write when the sequencer pops that cycle
        tx_push    = wr_data && (!tx_full || tx_pop);
        tx_ovf_set = wr_data && tx_full && !tx_pop;
        rx_pop     = rd_en && (bus_addr == 2'd0) && !rx_empty;
        rx_rise    = uart_rx_valid && !rx_valid_q && ctrl_q[1];
        rx_push    = rx_rise && (!rx_full || rx_pop);
        rx_ovr_set = rx_rise && rx_full && !rx_pop;
        status_w   = {25'b0, tx_ovf_q, rx_ovr_q, tx_idle, tx_full, tx_empty,
                      rx_full, !rx_empty};
    end

    // TX sequencer next state
    always_comb begin
        state_d = state_q;
        tx_pop  = 1'b0;
        case (state_q)
            T_IDLE: if (ctrl_q[0] && !tx_empty && !uart_tx_busy) begin
                tx_pop  = 1'b1;
                state_d = T_REQ;
            end
            T_REQ:  if (uart_tx_busy) state_d = T_WAIT;
            T_WAIT: if (!uart_tx_busy) state_d = T_IDLE;
            default: state_d = T_IDLE;
        endcase
    end

    // read data mux; reads while writing leave bus_rdata untouched
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (bus_addr)
                2'd0:    rdata_d = rx_empty ? 32'd0 : {23'b0, 1'b1, rx_mem_q[rx_rp_q]};
                2'd1:    rdata_d = status_w;
                2'd2:    rdata_d = {28'b0, ctrl_q};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    // FIFO storage, unreset since the pointers define validity
    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= bus_wdata[7:0];
        if (rx_push) rx_mem_q[rx_wp_q] <= uart_rx_byte;
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
            else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
            if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + 1'b1;
            else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
        end
    end

    // sequencer state and registered core handshake outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= T_IDLE;
            tx_byte_q  <= 8'd0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= (state_d == T_REQ);
            if (tx_pop) tx_byte_q <= tx_mem_q[tx_rp_q];
        end
    end

    // control/sticky registers, rx_valid edge history and read data
    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_q     <= 4'h3;
            rx_ovr_q   <= 1'b0;
            tx_ovf_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            rx_valid_q <= uart_rx_valid;
            rdata_q    <= rdata_d;
            if (wr_ctrl) ctrl_q <= bus_wdata[3:0];
            // a new event in the same cycle as its clear keeps the flag set
            rx_ovr_q <= rx_ovr_set || (rx_ovr_q && !(wr_status && bus_wdata[5]));
            tx_ovf_q <= tx_ovf_set || (tx_ovf_q && !(wr_status && bus_wdata[6]));
        end
    end

    assign bus_rdata     = rdata_q;
    assign uart_tx_byte  = tx_byte_q;
    assign uart_tx_start = tx_start_q;
    assign irq = (ctrl_q[2] && !rx_empty) || (ctrl_q[3] && tx_empty && tx_idle);

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl with a UART core model and TX/RX scoreboards.
module tb_uart_mmio_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  bus_addr = '0;
    logic        bus_wr = 1'b0;
    logic        bus_rd = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        irq;
    logic [7:0]  uart_tx_byte;
    logic        uart_tx_start;
    logic        uart_tx_busy = 1'b0;
    logic [7:0]  uart_rx_byte = '0;
    logic        uart_rx_valid = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [7:0]  tx_exp [$];
    logic [31:0] rx_exp [$];
    int          ph = 0;
    int          cnt = 0;
    logic [7:0]  cur = '0;

    uart_mmio_ctrl dut (
        .CLK(CLK), .RST(RST), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq),
        .uart_tx_byte(uart_tx_byte), .uart_tx_start(uart_tx_start),
        .uart_tx_busy(uart_tx_busy), .uart_rx_byte(uart_rx_byte),
        .uart_rx_valid(uart_rx_valid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // core model: raises busy 3 cycles after tx_start, holds it 3 cycles
    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                ph = 0; cnt = 0; uart_tx_busy = 1'b0;
            end else begin
                case (ph)
                    0: if (uart_tx_start) begin
                        cur = uart_tx_byte;
                        if (tx_exp.size() == 0) check("tx_unexpected_start", 32'(cur), 32'hFFFF_FFFF);
                        else check("tx_byte", 32'(cur), 32'(tx_exp.pop_front()));
                        cnt = 1; ph = 1;
                    end
                    1: begin
                        check("tx_start_held", 32'(uart_tx_start), 32'd1);
                        check("tx_byte_stable", 32'(uart_tx_byte), 32'(cur));
                        cnt++;
                        if (cnt == 3) begin uart_tx_busy = 1'b1; cnt = 0; ph = 2; end
                    end
                    default: begin
                        if (cnt == 0) check("tx_start_drop", 32'(uart_tx_start), 32'd0);
                        cnt++;
                        if (cnt == 3) begin uart_tx_busy = 1'b0; cnt = 0; ph = 0; end
                    end
                endcase
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge CLK); #1;
        bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
        @(posedge CLK); #1;
        bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge CLK); #1;
        bus_addr = a; bus_rd = 1'b1;
        @(posedge CLK); #1;
        bus_rd = 1'b0;
        d = bus_rdata;
    endtask

    task automatic read_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic read_data(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 32'd0;
        bus_read(2'd0, d);
        check(tag, d, e);
    endtask

    task automatic rx_pulse(input logic [7:0] b, input int len, input bit stored);
        @(posedge CLK); #1;
        uart_rx_byte = b; uart_rx_valid = 1'b1;
        if (stored) rx_exp.push_back(32'h100 | 32'(b));
        repeat (len) @(posedge CLK);
        #1 uart_rx_valid = 1'b0;
    endtask

    // rx_valid edge coincident with a DATA read
    task automatic rx_and_read(input logic [7:0] b, input string tag);
        logic [31:0] e;
        @(posedge CLK); #1;
        e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 32'd0;
        rx_exp.push_back(32'h100 | 32'(b));
        uart_rx_byte = b; uart_rx_valid = 1'b1; bus_addr = 2'd0; bus_rd = 1'b1;
        @(posedge CLK); #1;
        bus_rd = 1'b0; uart_rx_valid = 1'b0;
        check(tag, bus_rdata, e);
    endtask

    task automatic wait_tx_drain(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge CLK); #1;
            if (tx_exp.size() == 0 && ph == 0 && !uart_tx_busy && !uart_tx_start) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bit seen;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_tx_start", 32'(uart_tx_start), 32'd0);
        check("rst_tx_byte", 32'(uart_tx_byte), 32'd0);
        read_check(2'd1, 32'h14, "rst_status");
        read_check(2'd2, 32'h3, "rst_ctrl");

        // reserved address and simultaneous read/write
        bus_write(2'd3, 32'hFFFF_FFFF);
        read_check(2'd3, 32'd0, "addr3_read");
        read_check(2'd2, 32'h3, "ctrl_before_rdwr");
        @(posedge CLK); #1;
        bus_addr = 2'd2; bus_wdata = 32'hFFFF_FFF7; bus_wr = 1'b1; bus_rd = 1'b1;
        @(posedge CLK); #1;
        bus_wr = 1'b0; bus_rd = 1'b0;
        check("rdwr_rdata_hold", bus_rdata, 32'h3);
        read_check(2'd2, 32'h7, "ctrl_after_rdwr");
        bus_write(2'd2, 32'h3);

        // two-byte transmit through the handshake
        tx_exp.push_back(8'h41); bus_write(2'd0, 32'h41);
        tx_exp.push_back(8'h42); bus_write(2'd0, 32'h42);
        wait_tx_drain("tx2_drain");
        read_check(2'd1, 32'h14, "tx2_status_empty");

        // overflow with transmitter disabled, then release
        bus_write(2'd2, 32'h2);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) tx_exp.push_back(8'(8'h10 + i));
            bus_write(2'd0, 32'h10 + 32'(i));
        end
        read_check(2'd1, 32'h58, "tx_full_ovf_status");
        bus_write(2'd1, 32'h40);
        read_check(2'd1, 32'h18, "tx_ovf_cleared");
        bus_write(2'd2, 32'h3);
        wait_tx_drain("tx8_drain");
        read_check(2'd1, 32'h14, "tx8_status_empty");

        // held rx_valid gives a single push
        rx_pulse(8'h5A, 2, 1'b1);
        read_check(2'd1, 32'h15, "rx1_status");
        read_data("rx_5a");
        read_data("rx_empty_read");

        // empty FIFO: push and read in the same cycle
        rx_and_read(8'h3C, "rx_empty_same_cycle");
        read_data("rx_3c_stored");

        // fill, overrun, clear
        for (int i = 0; i < 8; i++) rx_pulse(8'(8'h60 + i), 1, 1'b1);
        read_check(2'd1, 32'h17, "rx_full_status");
        rx_pulse(8'h68, 1, 1'b0);
        read_check(2'd1, 32'h37, "rx_overrun_status");
        bus_write(2'd1, 32'h20);
        read_check(2'd1, 32'h17, "rx_overrun_cleared");
        rx_and_read(8'h69, "rx_full_same_cycle");
        read_check(2'd1, 32'h17, "rx_full_no_overrun");
        for (int i = 0; i < 8; i++) read_data("rx_drain");
        read_check(2'd1, 32'h14, "rx_drained_status");

        // interrupt sources
        bus_write(2'd2, 32'hC);
        check("irq_txe", 32'(irq), 32'd1);
        bus_write(2'd2, 32'h2);
        check("irq_off", 32'(irq), 32'd0);
        rx_pulse(8'h33, 1, 1'b1);
        @(posedge CLK); #1;
        check("irq_rx_masked", 32'(irq), 32'd0);
        bus_write(2'd2, 32'h6);
        check("irq_rx", 32'(irq), 32'd1);
        read_data("irq_rx_byte");
        check("irq_after_read", 32'(irq), 32'd0);
        bus_write(2'd2, 32'h3);

        // reset while a request is outstanding
        for (int i = 0; i < 3; i++) begin
            tx_exp.push_back(8'(8'h71 + i));
            bus_write(2'd0, 32'h71 + 32'(i));
        end
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (uart_tx_start) seen = 1'b1;
            else begin @(posedge CLK); #1; end
        end
        check("rst_req_seen", 32'(seen), 32'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("rst_mid_tx_start", 32'(uart_tx_start), 32'd0);
        RST = 1'b0;
        tx_exp.delete();
        read_check(2'd1, 32'h14, "rst_mid_status");
        read_check(2'd2, 32'h3, "rst_mid_ctrl");
        repeat (20) @(posedge CLK);
        #1;
        check("rst_no_tx", 32'(uart_tx_start), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
